// File: rtl/motor_stepper_driver_pkg.sv
// Shared definitions for the stepper driver: FSM state encoding, the
// full-step coil table and the command-active code.
package motor_stepper_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_POS = 2'd1,
        ST_RUN_NEG = 2'd2,
        ST_SETTLE  = 2'd3
    } state_e;

    // A command input only counts as asserted when it carries exactly this code.
    localparam logic [1:0] CMD_ACTIVE = 2'b01;

    // Full-step sequence; stepping forward walks up the table, backward walks down.
    localparam logic [3:0] PHASE_TABLE [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    function automatic logic [3:0] phase_of(input logic [1:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/motor_stepper_driver_if.sv
// Command/status bundle between an axis controller and one stepper driver.
interface motor_stepper_driver_if;
    logic [1:0]  cmd_pos;
    logic [1:0]  cmd_neg;
    logic [3:0]  phase;
    logic [15:0] angle;
    logic        moving;
    logic        at_limit;

    modport master (
        output cmd_pos,
        output cmd_neg,
        input  phase,
        input  angle,
        input  moving,
        input  at_limit
    );

    modport slave (
        input  cmd_pos,
        input  cmd_neg,
        output phase,
        output angle,
        output moving,
        output at_limit
    );
endinterface

// File: rtl/motor_stepper_driver_step_timer.sv
// Step-rate divider: counts 0..STEP_DIV-1 while enabled and pulses tc in
// the cycle whose clock edge issues a motor step.
module step_timer #(
    parameter int STEP_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == LAST);
    assign tc     = en & at_end;

    // Divider count; clear wins over enable, terminal count rolls back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/motor_stepper_driver.sv
// Single-axis full-step stepper driver with angle tracking. Instantiate one
// per axis (theta, phi). All outputs are registered; commands only steer
// the FSM.
module motor_stepper_driver
    import motor_stepper_driver_pkg::*;
#(
    parameter int STEP_DIV      = 50000,
    parameter int STEPS_PER_DEG = 2,
    parameter int WRAP          = 1,
    parameter int ANGLE_MAX     = 180,
    parameter int INIT_ANGLE    = 0,
    parameter int SETTLE_CYC    = 1000,
    parameter int HOLD_EN       = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    motor_stepper_driver_if.slave  bus
);
    localparam int SUB_W = (STEPS_PER_DEG > 1) ? $clog2(STEPS_PER_DEG) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [15:0]      INIT_A   = 16'(INIT_ANGLE);
    localparam logic [15:0]      MAX_A    = 16'(ANGLE_MAX);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_DEG - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    state_e           state;
    logic [SET_W-1:0] settle_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [1:0]       idx;
    logic             dir_neg;
    logic [3:0]       phase_r;
    logic [15:0]      angle_r;
    logic             moving_r;
    logic             at_limit_r;

    logic       pos_req, neg_req, pos_ok, neg_ok;
    logic       at_max, at_min;
    logic       running, step_tc;
    logic [1:0] idx_inc, idx_dec;

    function automatic logic [15:0] angle_up(input logic [15:0] a);
        if (WRAP != 0) return (a >= 16'd359) ? 16'd0 : a + 16'd1;
        else           return (a >= MAX_A) ? MAX_A : a + 16'd1;
    endfunction

    function automatic logic [15:0] angle_dn(input logic [15:0] a);
        if (WRAP != 0) return (a == 16'd0) ? 16'd359 : a - 16'd1;
        else           return (a == 16'd0) ? 16'd0 : a - 16'd1;
    endfunction

    function automatic logic limit_of(input logic [15:0] a);
        return (WRAP == 0) && ((a == 16'd0) || (a == MAX_A));
    endfunction

    function automatic logic [3:0] idle_phase(input logic [1:0] i);
        return (HOLD_EN != 0) ? phase_of(i) : 4'b0000;
    endfunction

    // Both commands active, or any code other than 01, means no request.
    assign pos_req = (bus.cmd_pos == CMD_ACTIVE) && (bus.cmd_neg != CMD_ACTIVE);
    assign neg_req = (bus.cmd_neg == CMD_ACTIVE) && (bus.cmd_pos != CMD_ACTIVE);
    assign at_max  = (WRAP == 0) && (angle_r == MAX_A);
    assign at_min  = (WRAP == 0) && (angle_r == 16'd0);
    assign pos_ok  = pos_req && !at_max;
    assign neg_ok  = neg_req && !at_min;
    assign running = (state == ST_RUN_POS) || (state == ST_RUN_NEG);
    assign idx_inc = idx + 2'd1;
    assign idx_dec = idx - 2'd1;

    // Timer is held at zero outside RUN, so every RUN entry starts a fresh
    // full step period and a partial step is dropped when RUN is left.
    step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!running),
        .en    (running),
        .tc    (step_tc)
    );

    // Driver FSM with registered phase/angle/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            sub_cnt    <= '0;
            idx        <= 2'd0;
            dir_neg    <= 1'b0;
            phase_r    <= 4'b0000;
            angle_r    <= INIT_A;
            moving_r   <= 1'b0;
            at_limit_r <= limit_of(INIT_A);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pos_ok) begin
                        state    <= ST_RUN_POS;
                        moving_r <= 1'b1;
                        phase_r  <= phase_of(idx);
                        if (dir_neg) begin
                            dir_neg <= 1'b0;
                            sub_cnt <= '0;
                        end
                    end else if (neg_ok) begin
                        state    <= ST_RUN_NEG;
                        moving_r <= 1'b1;
                        phase_r  <= phase_of(idx);
                        if (!dir_neg) begin
                            dir_neg <= 1'b1;
                            sub_cnt <= '0;
                        end
                    end else begin
                        phase_r <= idle_phase(idx);
                    end
                end

                ST_RUN_POS: begin
                    if (neg_req) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        moving_r   <= 1'b0;
                    end else if (!pos_req || at_max) begin
                        state    <= ST_IDLE;
                        moving_r <= 1'b0;
                        phase_r  <= idle_phase(idx);
                    end else if (step_tc) begin
                        idx     <= idx_inc;
                        phase_r <= phase_of(idx_inc);
                        if (sub_cnt == SUB_LAST) begin
                            sub_cnt    <= '0;
                            angle_r    <= angle_up(angle_r);
                            at_limit_r <= limit_of(angle_up(angle_r));
                        end else begin
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end
                end

                ST_RUN_NEG: begin
                    if (pos_req) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        moving_r   <= 1'b0;
                    end else if (!neg_req || at_min) begin
                        state    <= ST_IDLE;
                        moving_r <= 1'b0;
                        phase_r  <= idle_phase(idx);
                    end else if (step_tc) begin
                        idx     <= idx_dec;
                        phase_r <= phase_of(idx_dec);
                        if (sub_cnt == SUB_LAST) begin
                            sub_cnt    <= '0;
                            angle_r    <= angle_dn(angle_r);
                            at_limit_r <= limit_of(angle_dn(angle_r));
                        end else begin
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        if (pos_ok) begin
                            state    <= ST_RUN_POS;
                            moving_r <= 1'b1;
                            if (dir_neg) begin
                                dir_neg <= 1'b0;
                                sub_cnt <= '0;
                            end
                        end else if (neg_ok) begin
                            state    <= ST_RUN_NEG;
                            moving_r <= 1'b1;
                            if (!dir_neg) begin
                                dir_neg <= 1'b1;
                                sub_cnt <= '0;
                            end
                        end else begin
                            state   <= ST_IDLE;
                            phase_r <= idle_phase(idx);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.phase    = phase_r;
    assign bus.angle    = angle_r;
    assign bus.moving   = moving_r;
    assign bus.at_limit = at_limit_r;

endmodule

// File: tb/tb_motor_stepper_driver.sv
// Scoreboard bench for motor_stepper_driver: every change of the outputs is
// matched, including its clock cycle, against hand-computed expectations.
module tb_motor_stepper_driver;

    typedef struct packed {
        int          cyc;
        logic [3:0]  phase;
        logic [15:0] angle;
        logic        moving;
        logic        at_limit;
    } evt_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    evt_t q_a[$];
    evt_t q_b[$];
    evt_t cur_a, cur_b, prev_a, prev_b;

    motor_stepper_driver_if bus_a();
    motor_stepper_driver_if bus_b();

    // Wrapping axis starting at 359 with holding torque in IDLE.
    motor_stepper_driver #(
        .STEP_DIV(4), .STEPS_PER_DEG(2), .WRAP(1), .ANGLE_MAX(180),
        .INIT_ANGLE(359), .SETTLE_CYC(3), .HOLD_EN(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (bus_a)
    );

    // Clamped axis starting at its upper limit, coils released in IDLE.
    motor_stepper_driver #(
        .STEP_DIV(4), .STEPS_PER_DEG(2), .WRAP(0), .ANGLE_MAX(180),
        .INIT_ANGLE(180), .SETTLE_CYC(3), .HOLD_EN(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic outs_differ(input evt_t a, input evt_t b);
        return (a.phase != b.phase) || (a.angle != b.angle) ||
               (a.moving != b.moving) || (a.at_limit != b.at_limit);
    endfunction

    task automatic show_fail(input string nm, input evt_t g, input evt_t e);
        $display("FAIL %s: got cyc=%0d phase=%b angle=%0d moving=%b at_limit=%b, required cyc=%0d phase=%b angle=%0d moving=%b at_limit=%b",
                 nm, g.cyc, g.phase, g.angle, g.moving, g.at_limit,
                 e.cyc, e.phase, e.angle, e.moving, e.at_limit);
    endtask

    task automatic check_evt(input int id, input evt_t g);
        evt_t e;
        string nm;
        logic empty;
        nm = (id == 0) ? "evt_a" : "evt_b";
        empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        n_cmp++;
        if (empty) begin
            n_bad++;
            $display("FAIL %s_unexpected: got cyc=%0d phase=%b angle=%0d moving=%b at_limit=%b, required no output change",
                     nm, g.cyc, g.phase, g.angle, g.moving, g.at_limit);
        end else begin
            if (id == 0) e = q_a.pop_front();
            else         e = q_b.pop_front();
            if (e != g) begin
                n_bad++;
                show_fail(nm, g, e);
            end
        end
    endtask

    // Monitor: any output change while out of reset is a scoreboard event.
    always @(negedge clk) begin
        cur_a.cyc = cyc; cur_a.phase = bus_a.phase; cur_a.angle = bus_a.angle;
        cur_a.moving = bus_a.moving; cur_a.at_limit = bus_a.at_limit;
        cur_b.cyc = cyc; cur_b.phase = bus_b.phase; cur_b.angle = bus_b.angle;
        cur_b.moving = bus_b.moving; cur_b.at_limit = bus_b.at_limit;
        if (rst_a_n && outs_differ(cur_a, prev_a)) check_evt(0, cur_a);
        if (rst_b_n && outs_differ(cur_b, prev_b)) check_evt(1, cur_b);
        prev_a = cur_a;
        prev_b = cur_b;
    end

    task automatic exp_a(input int c, input logic [3:0] ph, input int ang, input logic mv, input logic lim);
        evt_t e;
        e.cyc = c; e.phase = ph; e.angle = 16'(ang); e.moving = mv; e.at_limit = lim;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input int c, input logic [3:0] ph, input int ang, input logic mv, input logic lim);
        evt_t e;
        e.cyc = c; e.phase = ph; e.angle = 16'(ang); e.moving = mv; e.at_limit = lim;
        q_b.push_back(e);
    endtask

    task automatic check_val(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   e;
        evt_t m;
        bus_a.cmd_pos = 2'b00; bus_a.cmd_neg = 2'b00;
        bus_b.cmd_pos = 2'b00; bus_b.cmd_neg = 2'b00;
        repeat (3) @(negedge clk);

        // Reset state of both axes.
        check_val("a_rst_phase",    int'(bus_a.phase), 0);
        check_val("a_rst_angle",    int'(bus_a.angle), 359);
        check_val("a_rst_moving",   int'(bus_a.moving), 0);
        check_val("a_rst_at_limit", int'(bus_a.at_limit), 0);
        check_val("b_rst_phase",    int'(bus_b.phase), 0);
        check_val("b_rst_angle",    int'(bus_b.angle), 180);
        check_val("b_rst_moving",   int'(bus_b.moving), 0);
        check_val("b_rst_at_limit", int'(bus_b.at_limit), 1);

        // Axis A leaves reset; holding phase appears on the first clock.
        t = cyc; rst_a_n = 1'b1;
        exp_a(t + 1, 4'b1100, 359, 1'b0, 1'b0);
        wait_until(t + 3);

        // Forward run, 16 cycles: four steps, 359 -> 0 -> 1.
        t = cyc; bus_a.cmd_pos = 2'b01; e = t + 1;
        exp_a(e,      4'b1100, 359, 1'b1, 1'b0);
        exp_a(e + 4,  4'b0110, 359, 1'b1, 1'b0);
        exp_a(e + 8,  4'b0011, 0,   1'b1, 1'b0);
        exp_a(e + 12, 4'b1001, 0,   1'b1, 1'b0);
        exp_a(e + 16, 4'b1100, 1,   1'b1, 1'b0);
        wait_until(e + 16);
        bus_a.cmd_pos = 2'b00;
        exp_a(e + 17, 4'b1100, 1, 1'b0, 1'b0);
        wait_until(e + 19);

        // Reversal at timer=2: 3-cycle settle, then backward through 0 -> 359.
        t = cyc; bus_a.cmd_pos = 2'b01; e = t + 1;
        exp_a(e,      4'b1100, 1,   1'b1, 1'b0);
        exp_a(e + 4,  4'b0110, 1,   1'b1, 1'b0);
        wait_until(e + 6);
        bus_a.cmd_pos = 2'b00; bus_a.cmd_neg = 2'b01;
        exp_a(e + 7,  4'b0110, 1,   1'b0, 1'b0);
        exp_a(e + 10, 4'b0110, 1,   1'b1, 1'b0);
        exp_a(e + 14, 4'b1100, 1,   1'b1, 1'b0);
        exp_a(e + 18, 4'b1001, 0,   1'b1, 1'b0);
        exp_a(e + 22, 4'b0011, 0,   1'b1, 1'b0);
        exp_a(e + 26, 4'b0110, 359, 1'b1, 1'b0);
        wait_until(e + 26);
        bus_a.cmd_neg = 2'b00;
        exp_a(e + 27, 4'b0110, 359, 1'b0, 1'b0);
        wait_until(e + 29);

        // Conflicting and non-01 command codes: no output may change.
        t = cyc;
        bus_a.cmd_pos = 2'b01; bus_a.cmd_neg = 2'b01;
        wait_until(t + 10);
        bus_a.cmd_neg = 2'b00; bus_a.cmd_pos = 2'b10;
        wait_until(t + 15);
        bus_a.cmd_pos = 2'b11;
        wait_until(t + 20);
        bus_a.cmd_pos = 2'b00; bus_a.cmd_neg = 2'b10;
        wait_until(t + 25);
        bus_a.cmd_neg = 2'b11;
        wait_until(t + 30);
        bus_a.cmd_neg = 2'b00;
        check_val("a_badcmd_moving", int'(bus_a.moving), 0);
        check_val("a_badcmd_phase",  int'(bus_a.phase), 'b0110);
        check_val("a_badcmd_angle",  int'(bus_a.angle), 359);

        // Asynchronous reset one cycle before a step is due.
        t = cyc; bus_a.cmd_pos = 2'b01; e = t + 1;
        exp_a(e, 4'b0110, 359, 1'b1, 1'b0);
        wait_until(e + 3);
        rst_a_n = 1'b0;
        #1;
        check_val("a_arst_phase",  int'(bus_a.phase), 0);
        check_val("a_arst_angle",  int'(bus_a.angle), 359);
        check_val("a_arst_moving", int'(bus_a.moving), 0);
        wait_until(e + 6);
        t = cyc; rst_a_n = 1'b1; bus_a.cmd_pos = 2'b00;
        exp_a(t + 1, 4'b1100, 359, 1'b0, 1'b0);
        wait_until(t + 3);

        // Operation resumes from a clean state after reset.
        t = cyc; bus_a.cmd_pos = 2'b01; e = t + 1;
        exp_a(e,     4'b1100, 359, 1'b1, 1'b0);
        exp_a(e + 4, 4'b0110, 359, 1'b1, 1'b0);
        exp_a(e + 8, 4'b0011, 0,   1'b1, 1'b0);
        wait_until(e + 8);
        bus_a.cmd_pos = 2'b00;
        exp_a(e + 9, 4'b0011, 0, 1'b0, 1'b0);
        wait_until(e + 11);

        // Axis B: release reset (phase stays 0000), then push against the clamp.
        t = cyc; rst_b_n = 1'b1;
        wait_until(t + 3);
        t = cyc; bus_b.cmd_pos = 2'b01;
        wait_until(t + 20);
        check_val("b_clamp_moving",   int'(bus_b.moving), 0);
        check_val("b_clamp_angle",    int'(bus_b.angle), 180);
        check_val("b_clamp_at_limit", int'(bus_b.at_limit), 1);
        check_val("b_clamp_phase",    int'(bus_b.phase), 0);

        // Step off the limit, reverse, and run back into it.
        t = cyc; bus_b.cmd_pos = 2'b00; bus_b.cmd_neg = 2'b01; e = t + 1;
        exp_b(e,      4'b1100, 180, 1'b1, 1'b1);
        exp_b(e + 4,  4'b1001, 180, 1'b1, 1'b1);
        exp_b(e + 8,  4'b0011, 179, 1'b1, 1'b0);
        exp_b(e + 9,  4'b0011, 179, 1'b0, 1'b0);
        exp_b(e + 12, 4'b0011, 179, 1'b1, 1'b0);
        exp_b(e + 16, 4'b1001, 179, 1'b1, 1'b0);
        exp_b(e + 20, 4'b1100, 180, 1'b1, 1'b1);
        exp_b(e + 21, 4'b0000, 180, 1'b0, 1'b1);
        wait_until(e + 8);
        bus_b.cmd_neg = 2'b00; bus_b.cmd_pos = 2'b01;
        wait_until(e + 30);
        bus_b.cmd_pos = 2'b00;
        wait_until(e + 33);
        check_val("b_end_moving",   int'(bus_b.moving), 0);
        check_val("b_end_angle",    int'(bus_b.angle), 180);
        check_val("b_end_at_limit", int'(bus_b.at_limit), 1);

        // Anything still queued never appeared on the outputs.
        while (q_a.size() > 0) begin
            m = q_a.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL evt_a_missing: got no output change, required cyc=%0d phase=%b angle=%0d moving=%b at_limit=%b",
                     m.cyc, m.phase, m.angle, m.moving, m.at_limit);
        end
        while (q_b.size() > 0) begin
            m = q_b.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL evt_b_missing: got no output change, required cyc=%0d phase=%b angle=%0d moving=%b at_limit=%b",
                     m.cyc, m.phase, m.angle, m.moving, m.at_limit);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_stepper_driver.md
MOTOR_STEPPER_DRIVER -- requirements
Module: motor_stepper_driver

Interface
REQ-001 Parameter STEP_DIV, default 50000: clk cycles per motor step.
REQ-002 Parameter STEPS_PER_DEG, default 2: motor steps per 1-degree angle change.
REQ-003 Parameter WRAP, default 1: 1 = angle wraps 0..359; 0 = angle clamps 0..ANGLE_MAX.
REQ-004 Parameter ANGLE_MAX, default 180: upper clamp when WRAP=0.
REQ-005 Parameter INIT_ANGLE, default 0: angle loaded at reset.
REQ-006 Parameter SETTLE_CYC, default 1000: dead cycles on direction reversal.
REQ-007 Parameter HOLD_EN, default 1: 1 = coils stay energized in IDLE; 0 = phase 0000 in IDLE.
REQ-008 clk  input  1  single system clock, rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 cmd_pos  input  2  positive-direction command; active only when value is 2'b01.
REQ-011 cmd_neg  input  2  negative-direction command; active only when value is 2'b01.
REQ-012 phase  output  4  coil drive, full-step sequence.
REQ-013 angle  output  16  current axis position in degrees, fed back as the actual-position input.
REQ-014 moving  output  1  high while in RUN_POS or RUN_NEG.
REQ-015 at_limit  output  1  high when WRAP=0 and angle equals 0 or ANGLE_MAX.

Function
REQ-016 Command decode: pos_req = (cmd_pos==01) and not (cmd_neg==01); neg_req symmetric; both active or any other code = no request.
REQ-017 FSM states IDLE, RUN_POS, RUN_NEG, SETTLE; registered, one transition per clk.
REQ-018 IDLE -> RUN_POS on pos_req, -> RUN_NEG on neg_req, unless blocked by clamp (REQ-025).
REQ-019 RUN_x -> IDLE when its request drops; RUN_x -> SETTLE when the opposite request appears.
REQ-020 SETTLE lasts exactly SETTLE_CYC cycles, phase held, no steps; then RUN of the current request, or IDLE if none.
REQ-021 Step timer cleared on every state entry; counts 0..STEP_DIV-1 in RUN_x; at terminal count one step issued, timer returns to 0; first step STEP_DIV cycles after RUN entry.
REQ-022 Partial step on leaving RUN_x is discarded; no step issued.
REQ-023 Phase index 2 bits: table 0=1100, 1=0110, 2=0011, 3=1001; RUN_POS step increments index mod 4, RUN_NEG decrements mod 4; phase updates in the same cycle as the step.
REQ-024 Sub-degree counter 0..STEPS_PER_DEG-1 counts steps in current direction; on wrap angle changes by +/-1 in the same cycle; counter clears on direction change.
REQ-025 WRAP=1: 359 +1 -> 0, 0 -1 -> 359. WRAP=0: at ANGLE_MAX pos_req is ignored (state stays/returns IDLE); at 0 neg_req is ignored; angle never leaves range.
REQ-026 phase in IDLE = table[index] if HOLD_EN=1 else 4'b0000; in RUN_x/SETTLE = table[index].
REQ-027 Outputs all registered; no combinational path from cmd_* to outputs.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, timer 0, sub-degree counter 0, index 0, angle INIT_ANGLE, phase 0000, moving 0, at_limit per INIT_ANGLE.
REQ-029 Reset mid-step or mid-SETTLE discards all progress; operation resumes from IDLE on first clk after rst_n rises.

Structure
REQ-030 Shared package holds the FSM state encoding, the 4-entry phase table and the 2'b01 command-active constant.
REQ-031 One sub-module, step_timer (clear, enable, terminal-count pulse, parameter STEP_DIV); instantiated once per driver; one driver instantiated per axis (theta, phi).

Verification (STEP_DIV=4, STEPS_PER_DEG=2, SETTLE_CYC=3 unless stated)
REQ-032 Reset, cmd_pos=01 for 16 cycles -> phase 1100,0110,0011,1001 changing every 4 cycles; angle 0->1 at cycle 8, ->2 at cycle 16; moving=1.
REQ-033 WRAP=1, INIT_ANGLE=359, cmd_pos=01 8 cycles -> angle 0; then cmd_neg=01 8 cycles -> angle 359 after 3-cycle SETTLE plus 8 cycles.
REQ-034 WRAP=0, ANGLE_MAX=180, INIT_ANGLE=180, cmd_pos=01 20 cycles -> state IDLE, phase constant, angle 180, at_limit=1, moving=0.
REQ-035 RUN_POS, switch to cmd_neg=01 at timer=2 -> moving=0 for 3 cycles, phase unchanged, first negative step 4 cycles after SETTLE exit, index decrements.
REQ-036 cmd_pos=01 and cmd_neg=01 together, and cmd_pos=10/11 -> no state change, no step.
REQ-037 rst_n low at timer=3 mid-RUN -> phase 0000, angle INIT_ANGLE immediately without clk; no step issued.
